output_bram_drain: RTL

//  Reader at the far end of the PE output BRAM: after a conv pass finishes accumulating, walks port B
//  (enb/addrb/doutb) over 0..num_pixels-1 and requantises each RESULT_WIDTH accumulator to PIXEL_WIDTH.

---
 rtl/conv2d_pkg.sv | 46 ++++
 rtl/output_bram_drain_skid_fifo.sv | 49 ++++
 rtl/output_bram_drain.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/conv2d_pkg.sv
// Shared definitions for the output BRAM drain: drain FSM states, default
// widths, and the requantise/saturate arithmetic used on every BRAM word.
package conv2d_pkg;

  localparam int unsigned DEF_RESULT_WIDTH = 48;
  localparam int unsigned DEF_PIXEL_WIDTH  = 16;
  localparam int unsigned DEF_ADDR_WIDTH   = 14;
  localparam int unsigned DEF_FRAC_SHIFT   = 8;
  localparam int unsigned LEAKY_SHIFT      = 3;

  // Wide enough for any RESULT_WIDTH up to 64 plus the rounding carry bit.
  localparam int unsigned CALC_W = 65;

  typedef logic signed [CALC_W-1:0] calc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_e;

  // Round half up, arithmetic shift, optional 1/8 negative slope, then clamp
  // to the signed range of pix_w bits. Caller truncates the result to pix_w.
  function automatic calc_t requantise(input calc_t       acc,
                                       input int unsigned frac_shift,
                                       input int unsigned pix_w,
                                       input bit          leaky);
    calc_t r;
    calc_t max_v;
    calc_t min_v;
    r = (acc + (calc_t'(1) <<< (frac_shift - 1))) >>> frac_shift;
    if (leaky && (r < 0)) begin
      r = r >>> LEAKY_SHIFT;
    end
    max_v = (calc_t'(1) <<< (pix_w - 1)) - calc_t'(1);
    min_v = -(calc_t'(1) <<< (pix_w - 1));
    if (r > max_v) begin
      r = max_v;
    end else if (r < min_v) begin
      r = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/output_bram_drain_skid_fifo.sv
// Two-entry skid FIFO holding requantised pixels with their last flag.
// Head entry is presented combinationally; occupancy is exported so the
// reader can throttle BRAM reads.
module drain_skid_fifo #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // Head of queue and status.
  always_comb begin
    o_data  = r_mem[r_rd_ptr];
    o_valid = (r_count != 2'd0);
    o_count = r_count;
  end

endmodule

// File: rtl/output_bram_drain.sv
// Output BRAM drain: reads port B over 0..num_pixels-1, requantises each
// accumulator to a signed pixel and streams it out with tlast.
// Optional feature macro: DRAIN_LEAKY_RELU_EN (negative results scaled by 1/8).
module output_bram_drain
  import conv2d_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int unsigned PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned FRAC_SHIFT   = DEF_FRAC_SHIFT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_WIDTH:0]            num_pixels,
  output logic                           busy,
  output logic                           done,
  output logic                           enb_output_BRAM,
  output logic [ADDR_WIDTH-1:0]          addrb_output_BRAM,
  input  logic signed [RESULT_WIDTH-1:0] BRAM_doutb,
  output logic signed [PIXEL_WIDTH-1:0]  m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast
);

`ifdef DRAIN_LEAKY_RELU_EN
  localparam bit LEAKY_EN = 1'b1;
`else
  localparam bit LEAKY_EN = 1'b0;
`endif

  localparam int unsigned FIFO_W = PIXEL_WIDTH + 1;

  typedef logic signed [PIXEL_WIDTH-1:0] pix_t;

  drain_state_e        r_state;
  drain_state_e        w_next;
  logic [ADDR_WIDTH:0] r_rd_cnt;
  logic [ADDR_WIDTH:0] r_num;
  logic                r_rd_pending;

  logic                w_start_ok;
  logic                w_reads_left;
  logic                w_issue;
  logic                w_pop;
  logic [1:0]          w_fifo_count;
  logic [2:0]          w_outstanding;
  logic                w_fifo_valid;
  logic [FIFO_W-1:0]   w_fifo_data;
  logic                w_last_push;
  pix_t                w_pix;

  // Read issue and stream handshake qualifiers.
  always_comb begin
    w_start_ok   = (r_state == IDLE) && start;
    w_reads_left = (r_rd_cnt != r_num);
    w_pop        = w_fifo_valid && m_tready;
    // Occupancy counts the entry leaving this cycle as already gone, so a
    // continuously ready consumer sustains one read (and one beat) per clock
    // while buffered plus in-flight words never exceed two after any edge.
    w_outstanding = 3'(w_fifo_count) - 3'(w_pop) + 3'(r_rd_pending);
    w_issue       = (r_state == RUN) && w_reads_left && (w_outstanding < 3'd2);
  end

  // Requantise the word returning from BRAM; its read was the most recent
  // issue, so it is the final pixel exactly when the read counter is spent.
  always_comb begin
    w_pix       = pix_t'(requantise(calc_t'(BRAM_doutb), FRAC_SHIFT, PIXEL_WIDTH, LEAKY_EN));
    w_last_push = (r_rd_cnt == r_num);
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Drain FSM next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (num_pixels == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!w_reads_left) begin
          w_next = FLUSH;
        end
      end
      FLUSH: begin
        if (w_pop && m_tlast) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Drain FSM status outputs.
  always_comb begin
    busy = (r_state == RUN) || (r_state == FLUSH);
    done = (r_state == DONE);
  end

  // Pixel count latch, read address counter and in-flight read flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num        <= '0;
      r_rd_cnt     <= '0;
      r_rd_pending <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_num    <= num_pixels;
        r_rd_cnt <= '0;
      end else if (w_issue) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      r_rd_pending <= w_issue;
    end
  end

  drain_skid_fifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rd_pending),
    .i_data  ({w_last_push, w_pix}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  // BRAM port B and stream outputs.
  always_comb begin
    enb_output_BRAM   = w_issue;
    addrb_output_BRAM = r_rd_cnt[ADDR_WIDTH-1:0];
    m_tvalid          = w_fifo_valid;
    m_tdata           = w_fifo_data[PIXEL_WIDTH-1:0];
    m_tlast           = w_fifo_valid && w_fifo_data[PIXEL_WIDTH];
  end

endmodule
